// File: rtl/svm_dwell_time_calc_pkg.sv
// Shared types and constants for the SVM dwell-time calculator.
package svm_dwell_time_calc_pkg;

    // Calculation sequence, one state per pipeline step of the carrier period
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SECT,
        ST_RD1,
        ST_MUL1,
        ST_RD2,
        ST_MUL2,
        ST_SUM,
        ST_ADJ,
        ST_OUT
    } state_t;

    // Sine samples are unsigned Q15
    localparam int Q15_SHIFT = 15;

    localparam logic [2:0] SECTOR_NONE = 3'd0;
    localparam logic [2:0] SECTOR_1    = 3'd1;
    localparam logic [2:0] SECTOR_2    = 3'd2;
    localparam logic [2:0] SECTOR_3    = 3'd3;
    localparam logic [2:0] SECTOR_4    = 3'd4;
    localparam logic [2:0] SECTOR_5    = 3'd5;
    localparam logic [2:0] SECTOR_6    = 3'd6;

    // Sector 1..6 from a phase that is already known to be below six spans.
    // A compare chain keeps this free of a divider.
    function automatic logic [2:0] sector_of(input int phase, input int span);
        if (phase < span)          return SECTOR_1;
        else if (phase < 2 * span) return SECTOR_2;
        else if (phase < 3 * span) return SECTOR_3;
        else if (phase < 4 * span) return SECTOR_4;
        else if (phase < 5 * span) return SECTOR_5;
        else                       return SECTOR_6;
    endfunction

endpackage

// File: rtl/svm_dwell_time_calc_if.sv
// Request/acknowledge link to the external Q15 sine look-up table.
interface svm_dwell_time_calc_if;

    logic        sin_req;
    logic [9:0]  sin_idx;
    logic        sin_ack;
    logic [15:0] sin_val;

    // The calculator asks for a sample, the LUT answers
    modport master (output sin_req, sin_idx, input sin_ack, sin_val);
    modport slave  (input sin_req, sin_idx, output sin_ack, sin_val);

endinterface

// File: rtl/svm_dwell_time_calc_q15_mul.sv
// Registered unsigned amplitude x Q15 multiply, result scaled back to ticks.
module svm_q15_mul
    import svm_dwell_time_calc_pkg::*;
#(
    parameter int AMP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [AMP_W-1:0] a,
    input  logic [15:0]      b,
    output logic [AMP_W:0]   p
);

    logic [AMP_W+15:0] prod;

    assign prod = (AMP_W + 16)'(a) * (AMP_W + 16)'(b);

    // Capture the truncated product whenever a fresh sine sample arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= prod[AMP_W+15:Q15_SHIFT];
        end
    end

endmodule

// File: rtl/svm_dwell_time_calc.sv
// Once per carrier period, converts amplitude/phase into a sector number and
// T1/T2/T0 dwell times in carrier ticks, with overmodulation limiting and
// minimum-pulse folding.
module svm_dwell_time_calc
    import svm_dwell_time_calc_pkg::*;
#(
    parameter int PWM_PERIOD  = 8000,
    parameter int AMP_MAX     = 9237,
    parameter int AMP_W       = 16,
    parameter int PHASE_W     = 16,
    parameter int PHASE_FULL  = 5760,
    parameter int SECTOR_SPAN = 960,
    parameter int T_W         = 14,
    parameter int T0_MIN      = 150,
    parameter int TX_MIN      = 300,
    parameter int MINPULSE_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  synchr_clk,
    input  logic                  enable,
    input  logic [AMP_W-1:0]      amplitude,
    input  logic [PHASE_W-1:0]    phase,
    svm_dwell_time_calc_if.master lut,
    output logic [2:0]            number_sector,
    output logic [T_W-1:0]        T1,
    output logic [T_W-1:0]        T2,
    output logic [T_W-1:0]        T0,
    output logic                  t_valid,
    output logic                  busy,
    output logic                  ovm,
    output logic                  overrun
);

    // Two spare bits above the amplitude keep t1+t2 and the folded sums exact
    localparam int CW = AMP_W + 2;

    state_t             state;
    logic               sync_q;
    logic               enable_q;
    logic [AMP_W-1:0]   amp_q;
    logic [PHASE_W-1:0] phase_q;
    logic [2:0]         sector_q;
    logic [9:0]         theta_q;
    logic [CW-1:0]      t1_q;
    logic [CW-1:0]      t2_q;
    logic [CW-1:0]      sum_q;

    logic               sync_fall;
    logic               start;
    logic               mul_en;
    logic [AMP_W:0]     mul_p;
    logic [AMP_W-1:0]   amp_clamped;
    logic [2:0]         sector_c;
    logic [9:0]         theta_c;
    logic [CW-1:0]      excess;
    logic [CW-1:0]      adj_t1;
    logic [CW-1:0]      adj_t2;
    logic [CW-1:0]      adj_t0;
    logic               adj_ovm;

    // Dwell times wider than the output port saturate instead of wrapping
    function automatic logic [T_W-1:0] clip_t(input logic [CW-1:0] v);
        return (v > CW'((1 << T_W) - 1)) ? '1 : v[T_W-1:0];
    endfunction

    assign sync_fall   = sync_q & ~synchr_clk;
    // enable_q blocks a start on the same cycle enable rises
    assign start       = sync_fall && enable && enable_q && (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign amp_clamped = (amplitude > AMP_W'(AMP_MAX)) ? AMP_W'(AMP_MAX) : amplitude;
    assign mul_en      = lut.sin_ack && ((state == ST_RD1) || (state == ST_RD2));

    svm_q15_mul #(
        .AMP_W (AMP_W)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mul_en),
        .a     (amp_q),
        .b     (lut.sin_val),
        .p     (mul_p)
    );

    // Sector number and angle inside the sector from the latched phase
    always_comb begin
        sector_c = sector_of(int'(phase_q), SECTOR_SPAN);
        theta_c  = 10'(int'(phase_q) - (int'(sector_c) - 1) * SECTOR_SPAN);
    end

    // Overmodulation limiting followed by minimum-pulse folding
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no path can
        // leave one unassigned and turn this block into a latch.
        excess  = '0;
        adj_t1  = t1_q;
        adj_t2  = t2_q;
        adj_t0  = '0;
        adj_ovm = 1'b0;

        if (sum_q > CW'(PWM_PERIOD)) begin
            excess  = sum_q - CW'(PWM_PERIOD);
            adj_t1  = (t1_q >= (excess >> 1)) ? t1_q - (excess >> 1) : '0;
            adj_t2  = (t2_q >= (excess - (excess >> 1))) ? t2_q - (excess - (excess >> 1)) : '0;
            adj_ovm = 1'b1;
        end else begin
            adj_t0 = (CW'(PWM_PERIOD) - sum_q) >> 1;
        end

        // Only the first rule that matches is applied
        if (MINPULSE_EN != 0) begin
            if (adj_t0 < CW'(T0_MIN)) begin
                adj_t1 = adj_t1 + adj_t0;
                adj_t2 = adj_t2 + adj_t0;
                adj_t0 = '0;
            end else if (adj_t1 < CW'(TX_MIN)) begin
                adj_t2 = adj_t2 + (adj_t1 >> 1);
                adj_t0 = adj_t0 + (adj_t1 >> 1);
                adj_t1 = '0;
            end else if (adj_t2 < CW'(TX_MIN)) begin
                adj_t1 = adj_t1 + (adj_t2 >> 1);
                adj_t0 = adj_t0 + (adj_t2 >> 1);
                adj_t2 = '0;
            end
        end
    end

    // Calculation sequencer with registered results, strobes and LUT request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sync_q        <= 1'b0;
            enable_q      <= 1'b0;
            amp_q         <= '0;
            phase_q       <= '0;
            sector_q      <= SECTOR_NONE;
            theta_q       <= '0;
            t1_q          <= '0;
            t2_q          <= '0;
            sum_q         <= '0;
            lut.sin_req   <= 1'b0;
            lut.sin_idx   <= '0;
            number_sector <= SECTOR_NONE;
            T1            <= '0;
            T2            <= '0;
            T0            <= '0;
            t_valid       <= 1'b0;
            ovm           <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge value of every other, independent of statement order.
            sync_q   <= synchr_clk;
            enable_q <= enable;
            t_valid  <= 1'b0;
            overrun  <= 1'b0;

            if (!enable) begin
                state         <= ST_IDLE;
                lut.sin_req   <= 1'b0;
                number_sector <= SECTOR_NONE;
                T1            <= '0;
                T2            <= '0;
                T0            <= '0;
                ovm           <= 1'b0;
            end else begin
                // A sync edge arriving mid-calculation is dropped and flagged
                if (sync_fall && busy) begin
                    overrun <= 1'b1;
                end

                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            amp_q <= amp_clamped;
                            if (phase < PHASE_W'(PHASE_FULL)) begin
                                phase_q <= phase;
                            end
                            state <= ST_SECT;
                        end
                    end
                    ST_SECT: begin
                        sector_q    <= sector_c;
                        theta_q     <= theta_c;
                        lut.sin_idx <= 10'(SECTOR_SPAN) - theta_c;
                        lut.sin_req <= 1'b1;
                        state       <= ST_RD1;
                    end
                    ST_RD1: begin
                        if (lut.sin_ack) begin
                            lut.sin_req <= 1'b0;
                            state       <= ST_MUL1;
                        end
                    end
                    ST_MUL1: begin
                        t1_q        <= CW'(mul_p);
                        lut.sin_idx <= theta_q;
                        lut.sin_req <= 1'b1;
                        state       <= ST_RD2;
                    end
                    ST_RD2: begin
                        if (lut.sin_ack) begin
                            lut.sin_req <= 1'b0;
                            state       <= ST_MUL2;
                        end
                    end
                    ST_MUL2: begin
                        t2_q  <= CW'(mul_p);
                        state <= ST_SUM;
                    end
                    ST_SUM: begin
                        sum_q <= t1_q + t2_q;
                        state <= ST_ADJ;
                    end
                    ST_ADJ: begin
                        // Even sectors traverse their two active vectors in reverse order
                        if (sector_q[0]) begin
                            T1 <= clip_t(adj_t1);
                            T2 <= clip_t(adj_t2);
                        end else begin
                            T1 <= clip_t(adj_t2);
                            T2 <= clip_t(adj_t1);
                        end
                        T0            <= clip_t(adj_t0);
                        number_sector <= sector_q;
                        ovm           <= adj_ovm;
                        t_valid       <= 1'b1;
                        state         <= ST_OUT;
                    end
                    ST_OUT: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_svm_dwell_time_calc.sv
// Self-checking bench for svm_dwell_time_calc: directed vector table, hand
// sequences for stall/overrun/disable/reset, then randomized traffic against
// an arithmetic reference model.
module tb_svm_dwell_time_calc;

    typedef struct {
        int sector;
        int t1;
        int t2;
        int t0;
        int ovm;
    } exp_t;

    typedef struct {
        int   amp;
        int   phase;
        int   s1;
        int   s2;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        synchr_clk;
    logic        enable;
    logic [15:0] amplitude;
    logic [15:0] phase;
    logic [2:0]  number_sector;
    logic [13:0] T1;
    logic [13:0] T2;
    logic [13:0] T0;
    logic        t_valid;
    logic        busy;
    logic        ovm;
    logic        overrun;

    logic        ack_en   = 1'b1;
    logic        stall_en = 1'b0;
    logic        stall    = 1'b0;

    int          lut [0:1023];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_phase = 0;
    vec_t        vecs [6];

    svm_dwell_time_calc_if lut_if ();

    svm_dwell_time_calc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .synchr_clk    (synchr_clk),
        .enable        (enable),
        .amplitude     (amplitude),
        .phase         (phase),
        .lut           (lut_if),
        .number_sector (number_sector),
        .T1            (T1),
        .T2            (T2),
        .T0            (T0),
        .t_valid       (t_valid),
        .busy          (busy),
        .ovm           (ovm),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Random LUT wait states
    always @(posedge clk) stall <= stall_en && ($urandom_range(0, 3) == 0);

    // LUT model: answers in the same cycle unless stalled or held off
    assign lut_if.sin_ack = lut_if.sin_req & ack_en & ~stall;
    assign lut_if.sin_val = 16'(lut[lut_if.sin_idx]);

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic init_lut();
        for (int i = 0; i < 1024; i++) begin
            lut[i] = (i <= 960) ? $rtoi(32767.0 * $sin(real'(i) * 3.14159265358979 / 2880.0) + 0.5) : 0;
        end
    endtask

    // Dwell times straight from the arithmetic rules, on plain integers
    function automatic void ref_model(input int amp, input int ph, output exp_t r);
        int a, th, t1, t2, t0, s, e, tmp;
        if (ph < 5760) model_phase = ph;
        a        = (amp > 9237) ? 9237 : amp;
        r.sector = model_phase / 960 + 1;
        th       = model_phase % 960;
        t1       = (a * lut[960 - th]) / 32768;
        t2       = (a * lut[th]) / 32768;
        s        = t1 + t2;
        r.ovm    = 0;
        if (s > 8000) begin
            e     = s - 8000;
            t1    = (t1 - e / 2 < 0) ? 0 : t1 - e / 2;
            t2    = (t2 - (e - e / 2) < 0) ? 0 : t2 - (e - e / 2);
            t0    = 0;
            r.ovm = 1;
        end else begin
            t0 = (8000 - s) / 2;
        end
        if (t0 < 150) begin
            t1 += t0; t2 += t0; t0 = 0;
        end else if (t1 < 300) begin
            t2 += t1 / 2; t0 += t1 / 2; t1 = 0;
        end else if (t2 < 300) begin
            t1 += t2 / 2; t0 += t2 / 2; t2 = 0;
        end
        if (r.sector % 2 == 0) begin
            tmp = t1; t1 = t2; t2 = tmp;
        end
        r.t1 = t1;
        r.t2 = t2;
        r.t0 = t0;
    endfunction

    // Falling sync edge, then wait (bounded) for the result strobe
    task automatic run_calc(input int amp, input int ph, output int lat);
        amplitude  = 16'(amp);
        phase      = 16'(ph);
        synchr_clk = 1'b1;
        @(negedge clk);
        synchr_clk = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (t_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sector"},  int'(number_sector), 0);
        check({tag, "_T1"},      int'(T1), 0);
        check({tag, "_T2"},      int'(T2), 0);
        check({tag, "_T0"},      int'(T0), 0);
        check({tag, "_t_valid"}, int'(t_valid), 0);
        check({tag, "_busy"},    int'(busy), 0);
        check({tag, "_ovm"},     int'(ovm), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_sin_req"}, int'(lut_if.sin_req), 0);
    endtask

    task automatic check_result(input string tag, input exp_t e);
        check({tag, "_sector"}, int'(number_sector), e.sector);
        check({tag, "_T1"},     int'(T1), e.t1);
        check({tag, "_T2"},     int'(T2), e.t2);
        check({tag, "_T0"},     int'(T0), e.t0);
        check({tag, "_ovm"},    int'(ovm), e.ovm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   eff;
        int   th;
        exp_t r;

        rst_n      = 1'b0;
        synchr_clk = 1'b0;
        enable     = 1'b0;
        amplitude  = '0;
        phase      = '0;
        init_lut();

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // amp, phase, LUT(SPAN-theta), LUT(theta), {sector, T1, T2, T0, ovm}
        vecs[0] = '{4000,  480,  16384, 16384, '{1, 2000, 2000, 2000, 0}};
        vecs[1] = '{4000,  5760, 16384, 16384, '{1, 2000, 2000, 2000, 0}};
        vecs[2] = '{8000,  1200, 23170, 8481,  '{2, 2207, 5793, 0,    0}};
        vecs[3] = '{12000, 480,  16384, 16384, '{1, 4000, 4000, 0,    1}};
        vecs[4] = '{4000,  30,   27840, 1072,  '{1, 3463, 0,    2301, 0}};
        vecs[5] = '{6000,  5700, 2143,  27245, '{6, 4988, 392,  1310, 0}};

        for (int i = 0; i < 6; i++) begin
            eff = (vecs[i].phase < 5760) ? vecs[i].phase : model_phase;
            model_phase = eff;
            th = eff % 960;
            lut[960 - th] = vecs[i].s1;
            lut[th]       = vecs[i].s2;
            run_calc(vecs[i].amp, vecs[i].phase, lat);
            check($sformatf("v%0d_latency", i), lat, 8);
            check_result($sformatf("v%0d", i), vecs[i].e);
            @(negedge clk);
            check($sformatf("v%0d_strobe_end", i), int'(t_valid), 0);
            check($sformatf("v%0d_T1_hold", i), int'(T1), vecs[i].e.t1);
        end
        init_lut();

        // LUT never answers: calculation parks in RD1
        ack_en     = 1'b0;
        amplitude  = 16'd4000;
        phase      = 16'd480;
        model_phase = 480;
        synchr_clk = 1'b1;
        @(negedge clk);
        synchr_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_busy", int'(busy), 1);
        check("stall_req", int'(lut_if.sin_req), 1);
        check("stall_idx", int'(lut_if.sin_idx), 480);

        // Second sync edge while busy
        synchr_clk = 1'b1;
        @(negedge clk);
        synchr_clk = 1'b0;
        @(negedge clk);
        check("ovr_pulse", int'(overrun), 1);
        check("ovr_busy", int'(busy), 1);
        @(negedge clk);
        check("ovr_pulse_end", int'(overrun), 0);
        check("ovr_busy_hold", int'(busy), 1);
        check("ovr_idx_stable", int'(lut_if.sin_idx), 480);

        // Abort
        enable = 1'b0;
        @(negedge clk);
        check_all_zero("disable");

        // Sync edge in the same cycle enable rises must not start
        synchr_clk = 1'b1;
        @(negedge clk);
        enable     = 1'b1;
        synchr_clk = 1'b0;
        repeat (2) @(negedge clk);
        check("en_edge_nostart", int'(busy), 0);
        ack_en = 1'b1;

        // Normal calculation to load non-zero outputs
        ref_model(5000, 2000, r);
        run_calc(5000, 2000, lat);
        check("pre_reset_latency", lat, 8);
        check_result("pre_reset", r);

        // Asynchronous reset while in RD2
        amplitude   = 16'd4000;
        phase       = 16'd960;
        synchr_clk  = 1'b1;
        @(negedge clk);
        synchr_clk  = 1'b0;
        repeat (4) @(negedge clk);
        check("rd2_req", int'(lut_if.sin_req), 1);
        check("rd2_idx", int'(lut_if.sin_idx), 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_phase = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Randomized traffic with LUT wait states
        stall_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            int amp;
            int ph;
            amp = $urandom_range(0, 12000);
            ph  = $urandom_range(0, 6100);
            ref_model(amp, ph, r);
            run_calc(amp, ph, lat);
            check($sformatf("rnd%0d_done", i), int'(lat > 0), 1);
            check_result($sformatf("rnd%0d", i), r);
        end
        stall_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
